bus_stream_master: RTL and testbench
====================================

# bus_stream_master

Parametrised successor to the fixed 8-bit bus master. It accepts words from a local producer, buffers them in a DEPTH-entry FIFO, and drives them onto a `bus_if`-style valid/ready bus with strict hold-until-accepted semantics. It also frames fixed-length bursts with an `out_last` marker. It sits between a data-producing engine and the `bus_if.master` modport side of the interconnect.

## Interface
- `DATA_W`, default 8: data width in bits, ≥1.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `BURST_LEN`, default 4: beats per burst, ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high, sampled on `clk` rising edge.
- `in_valid`  in  1  producer offers `in_data`.
- `in_data`  in  DATA_W  producer word.
- `in_ready`  out  1  FIFO can accept; equals `!full`.
- `out_valid`  out  1  bus word valid; maps to `bus_if.valid`.
- `out_data`  out  DATA_W  bus word; maps to `bus_if.data`.
- `out_last`  out  1  current beat is the final beat of a burst.
- `out_ready`  in  1  bus sink accepts; maps to `bus_if.ready`.
- `level`  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Push happens when `in_valid && in_ready`. Pop happens when `out_valid && out_ready`.
- The FIFO is first-word fall-through. `out_data` is always the head entry, and `out_valid = (level != 0)`.
- Hold rule: while `out_valid && !out_ready`, `out_data` and `out_last` stay stable and `out_valid` stays high. The block never retracts `out_valid` without a pop.
- `in_ready` depends only on registered state. It has no combinational path from `out_ready`.
- When full, a push is refused even if a pop occurs in the same cycle. Push reopens the cycle after the pop.
- Push and pop in the same cycle when not full and not empty: `level` is unchanged, and both pointers advance.
- Push when empty: the word is visible on `out_*` in the next cycle, not the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty are derived from `level`, not from pointer comparison.
- Beat counter `beat`, $clog2(BURST_LEN) bits (1 bit if BURST_LEN=1):
  - It increments on each pop.
  - It wraps to 0 after the pop at BURST_LEN-1.
  - `out_last = out_valid && (beat == BURST_LEN-1)`.
  - With BURST_LEN=1, `out_last` equals `out_valid`.
- The beat counter counts only pops. It does not depend on FIFO contents.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `in_ready`=1, `level`=0, `beat`=0, pointers=0, `out_data`=0.
- Reset mid-operation: all buffered words are discarded, and any partial burst count is dropped. On the cycle after `rst` deasserts, the block is empty and `in_ready`=1.
- Latency from input to bus is 1 cycle when empty. Throughput is 1 word/cycle sustained when `out_ready` is held high and the FIFO is not full.
- `level` updates on the clock edge after the push or pop.
- Storage contents are not reset; only the control state is.

## Configuration
- Macro: `BUS_STREAM_MASTER_PARITY_EN`.
- Defined:
  - Adds output `out_parity` (1 bit) = `^out_data` (even parity), held stable under the same hold rule.
  - Adds input `in_parity_err_inj` (1 bit). When high at push, the stored parity bit is inverted for that word. Parity is stored per entry, so FIFO width becomes DATA_W+1.
- Undefined: neither port exists, and the FIFO is DATA_W wide.

## Structure
- Package `bus_stream_pkg`:
  - Default-width localparams.
  - `typedef struct packed` for a FIFO entry (data, plus parity under the macro).
  - Function `clog2_min1` for counter widths.
- Sub-module `bus_stream_fifo_mem`: storage array, read/write pointers and `level`. The parent holds the handshake, beat counter and `out_last`.

## Test plan
- Reset then single push of 8'hAA with `out_ready`=1 → `out_valid`=1 with `out_data`=8'hAA one cycle later, popped that cycle, `level` back to 0.
- Hold: push 8'h11, 8'h22 with `out_ready`=0 for 5 cycles → `out_data` stays 8'h11 and `out_valid` stays 1 throughout. Raise `out_ready` → 8'h11 then 8'h22 on consecutive cycles.
- Full, DEPTH=4: push 5 words with `out_ready`=0 → `in_ready`=0 after the 4th and the 5th is refused, `level`=4. One pop → `in_ready`=1 the next cycle.
- Burst, BURST_LEN=4: stream 10 words at `out_ready`=1 → `out_last` high on beats 4 and 8 only. Reset mid-burst after beat 2 → the next accepted beat is counted as beat 1 of a new burst.
- Wrap plus simultaneous push and pop: 20 words with random `out_ready` → output order equals input order, `level` never exceeds 4, `level` unchanged on push-and-pop cycles.
- With `BUS_STREAM_MASTER_PARITY_EN`: push 8'h07 → `out_parity`=1. Push 8'h07 with `in_parity_err_inj`=1 → `out_parity`=0.

Source files
------------

// File: rtl/bus_stream_master_pkg.sv
// Shared definitions for bus_stream_master: default widths, the counter-width
// helper and the default-width FIFO entry layout.
// Optional feature macro: BUS_STREAM_MASTER_PARITY_EN (adds a per-entry parity bit).
package bus_stream_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int DEPTH_DEF     = 4;
  localparam int BURST_LEN_DEF = 4;

  // Width of a counter covering n states; never narrower than one bit so a
  // single-state counter still has a legal declaration.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // FIFO entry at the default data width; parity rides above the data bits.
  typedef struct packed {
`ifdef BUS_STREAM_MASTER_PARITY_EN
    logic                  par;
`endif
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/bus_stream_master_if.sv
// Valid/ready bus between bus_stream_master (master) and the interconnect (slave).
// Optional feature macro: BUS_STREAM_MASTER_PARITY_EN (adds the parity line).
interface bus_stream_master_if #(
  parameter int DATA_W = 8
);

  logic              valid;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              ready;
`ifdef BUS_STREAM_MASTER_PARITY_EN
  logic              parity;
`endif

  modport master (
    output valid,
    output data,
    output last,
`ifdef BUS_STREAM_MASTER_PARITY_EN
    output parity,
`endif
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
`ifdef BUS_STREAM_MASTER_PARITY_EN
    input  parity,
`endif
    output ready
  );

endinterface

// File: rtl/bus_stream_master_fifo_mem.sv
// First-word-fall-through storage for bus_stream_master: entry array, wrapping
// read/write pointers and occupancy. Only pointers and level are reset; the
// entry array keeps whatever it held.
module bus_stream_fifo_mem
  import bus_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Entry write; storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/bus_stream_master.sv
// bus_stream_master: buffers producer words in a DEPTH-entry FWFT FIFO and
// presents them on a hold-until-accepted valid/ready bus, marking every
// BURST_LEN-th accepted beat with last.
// Optional feature macro: BUS_STREAM_MASTER_PARITY_EN (per-entry even parity
// with an error-injection input).
module bus_stream_master
  import bus_stream_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
`ifdef BUS_STREAM_MASTER_PARITY_EN
  input  logic                       in_parity_err_inj,
`endif
  output logic                       in_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  bus_stream_master_if.master        bus
);

  localparam int LVL_W  = $clog2(DEPTH+1);
  localparam int BEAT_W = clog2_min1(BURST_LEN);
`ifdef BUS_STREAM_MASTER_PARITY_EN
  localparam int ENTRY_W = DATA_W + 1;
`else
  localparam int ENTRY_W = DATA_W;
`endif
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic [BEAT_W-1:0]  beat;

  // Full is judged from registered occupancy only, so a pop in the same cycle
  // cannot reopen the input until the following cycle.
  assign in_ready  = (level != LVL_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign bus.valid = (level != '0);
  assign pop       = bus.valid && bus.ready;

`ifdef BUS_STREAM_MASTER_PARITY_EN
  // Parity is captured at push time; injection flips the stored bit for that word only.
  assign wr_entry   = {(^in_data) ^ in_parity_err_inj, in_data};
  assign bus.parity = bus.valid & rd_entry[DATA_W];
`else
  assign wr_entry   = in_data;
`endif

  // Head entry is shown only while valid so an empty FIFO drives zero data.
  assign bus.data = bus.valid ? rd_entry[DATA_W-1:0] : '0;
  assign bus.last = bus.valid && (beat == LAST_BEAT);

  bus_stream_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .level   (level)
  );

  // Burst beat counter: advances on accepted beats only, wrapping after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
    end else if (pop) begin
      beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
    end
  end

endmodule

// File: tb/tb_bus_stream_master.sv
// Scoreboard bench for bus_stream_master (DATA_W=8, DEPTH=4, BURST_LEN=4).
// Build with BUS_STREAM_MASTER_PARITY_EN defined to include the parity checks.
module tb_bus_stream_master;

  localparam int DEPTH = 4;
  localparam int BL    = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [2:0] level;
`ifdef BUS_STREAM_MASTER_PARITY_EN
  logic       inj;
`endif

  bus_stream_master_if #(.DATA_W(8)) bus ();

  bus_stream_master #(
    .DATA_W    (8),
    .DEPTH     (DEPTH),
    .BURST_LEN (BL)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_data           (in_data),
`ifdef BUS_STREAM_MASTER_PARITY_EN
    .in_parity_err_inj (inj),
`endif
    .in_ready          (in_ready),
    .level             (level),
    .bus               (bus)
  );

  typedef struct {
    logic [7:0] d;
`ifdef BUS_STREAM_MASTER_PARITY_EN
    logic       p;
`endif
  } exp_t;

  exp_t sbq[$];
  int   pops;
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: reference behaviour is "FIFO in order, last on every BL-th pop since reset".
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", {31'd0, bus.valid}, {31'd0, sbq.size() != 0});
      chk("level", {29'd0, level}, sbq.size());
      chk("in_ready", {31'd0, in_ready}, {31'd0, sbq.size() != DEPTH});
      if (sbq.size() != 0) begin
        chk("out_data", {24'd0, bus.data}, {24'd0, sbq[0].d});
        chk("out_last", {31'd0, bus.last}, {31'd0, (pops % BL) == BL - 1});
`ifdef BUS_STREAM_MASTER_PARITY_EN
        chk("out_parity", {31'd0, bus.parity}, {31'd0, sbq[0].p});
`endif
        if (bus.ready) begin
          void'(sbq.pop_front());
          pops++;
        end
      end else begin
        chk("idle_data", {24'd0, bus.data}, 32'd0);
        chk("idle_last", {31'd0, bus.last}, 32'd0);
      end
    end
  end

  // One clock of stimulus; an accepted word is recorded as expected output.
  task automatic step(input logic iv, input logic [7:0] d, input logic rdy);
    exp_t e;
    in_valid  = iv;
    in_data   = d;
    bus.ready = rdy;
    @(negedge clk);
    #1;
    if (iv && in_ready) begin
      e.d = d;
`ifdef BUS_STREAM_MASTER_PARITY_EN
      e.p = (^d) ^ inj;
`endif
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    sbq.delete();
    pops = 0;
    rst  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_empty", sbq.size(), 32'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    pops      = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    bus.ready = 1'b0;
`ifdef BUS_STREAM_MASTER_PARITY_EN
    inj       = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    step(1'b0, 8'h00, 1'b0);

    // Single word, 1-cycle latency
    step(1'b1, 8'hAA, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("single_level", {29'd0, level}, 32'd0);

    // Hold under backpressure
    do_reset();
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

    // Full: fifth word refused, reopen one cycle after a pop
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
    chk("full_level", {29'd0, level}, 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 8'h3F, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    drain();

    // Bursts of 10, then reset mid-burst
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 8'h50 + 8'(i), 1'b1);
    drain();
    do_reset();
    for (int i = 0; i < 2; i++) step(1'b1, 8'h60 + 8'(i), 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 8'h70 + 8'(i), 1'b1);
    drain();

    // Random traffic with wrap and simultaneous push/pop, one random reset
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();

`ifdef BUS_STREAM_MASTER_PARITY_EN
    // Parity and error injection
    do_reset();
    step(1'b1, 8'h07, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    inj = 1'b1;
    step(1'b1, 8'h07, 1'b1);
    inj = 1'b0;
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 40; i++) begin
      inj = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    inj = 1'b0;
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
